// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline sequencer for the 5-stage core. It turns load-use hazards, taken
//   branches, data-memory wait states and ECALL into the stall/flush controls
//   for the PC, the IF/ID register and the ID/EX register. It also owns the
//   halt sequence (RUN -> DRAIN -> HALTED) and two performance counters.
//
//   Ports
//     clk          clock; all state updates on the rising edge
//     rst          synchronous active-high reset
//     id_rs1/2     source registers of the instruction in ID
//     id_use_rs1/2 ID instruction actually reads rs1 / rs2
//     ex_rd        destination register of the instruction in EX
//     ex_memread   EX instruction is a load
//     ex_br_taken  branch/jump in EX resolved taken this cycle
//     ex_stop      ECALL in EX
//     mem_busy     data memory not ready; whole pipe freezes
//     resume       debug pulse that leaves HALTED
//     cnt_clr      clears both performance counters
//     stall_f      hold PC
//     stall_d      hold IF/ID
//     stall_e      hold ID/EX, EX/MEM, MEM/WB
//     flush_d      load a bubble into IF/ID
//     eflush       load a bubble into ID/EX
//     halted       core is halted
//     stall_cnt    number of cycles with stall_f asserted (wraps)
//     flush_cnt    number of taken-branch flush events (wraps)
//
//   Control outputs are combinational from the current state and inputs;
//   only the halt FSM, the drain counter and the perf counters are registered.

module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_br_taken,
  input  logic             ex_stop,
  input  logic             mem_busy,
  input  logic             resume,
  input  logic             cnt_clr,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             flush_d,
  output logic             eflush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Drain counter only needs to reach DRAIN_CYCLES-1; keep at least one bit.
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  state_t        state, state_nxt;
  logic [DW-1:0] drain_cnt, drain_cnt_nxt;
  logic          load_use;
  logic          br_event;

  // A load in EX whose destination is read by the instruction in ID. x0 never
  // creates a dependency because it is hard-wired to zero.
  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (ex_rd == id_rs1)) ||
                     (id_use_rs2 && (ex_rd == id_rs2)));

  // State and drain counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // Next-state and control outputs. In RUN a memory wait freezes the whole
  // pipe and defers every other event, so a branch or ECALL sitting in EX is
  // acted on (and counted) only once the memory is ready. During DRAIN and
  // HALTED the front end keeps injecting bubbles so nothing younger than the
  // ECALL can retire.
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    stall_f       = 1'b0;
    stall_d       = 1'b0;
    stall_e       = 1'b0;
    flush_d       = 1'b0;
    eflush        = 1'b0;
    halted        = 1'b0;
    br_event      = 1'b0;

    case (state)
      RUN: begin
        if (mem_busy) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
        end else if (ex_br_taken) begin
          // The redirect kills the load-use victim, so no stall is needed.
          flush_d  = 1'b1;
          eflush   = 1'b1;
          br_event = 1'b1;
        end else if (ex_stop) begin
          flush_d       = 1'b1;
          eflush        = 1'b1;
          stall_f       = 1'b1;
          state_nxt     = DRAIN;
          drain_cnt_nxt = '0;
        end else if (load_use) begin
          // Next cycle the load is in MEM and the hazard is gone, which
          // guarantees exactly one bubble per hazard.
          stall_f = 1'b1;
          stall_d = 1'b1;
          eflush  = 1'b1;
        end
      end

      DRAIN: begin
        stall_f = 1'b1;
        flush_d = 1'b1;
        eflush  = 1'b1;
        if (mem_busy) begin
          stall_e = 1'b1;
        end else if (drain_cnt == DRAIN_LAST) begin
          state_nxt = HALTED;
        end else begin
          drain_cnt_nxt = drain_cnt + DW'(1);
        end
      end

      HALTED: begin
        halted  = 1'b1;
        stall_f = 1'b1;
        flush_d = 1'b1;
        eflush  = 1'b1;
        if (resume) begin
          state_nxt = RUN;
        end
      end

      default: begin
        state_nxt     = RUN;
        drain_cnt_nxt = '0;
      end
    endcase
  end

  // Performance counters. Clear takes priority over any event in the same
  // cycle; both counters wrap naturally at their width.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (br_event) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Self-checking bench for hazard_ctrl. A behavioural model tracks the halt
//   sequence as "drain cycles still owed" plus a halted flag, and the counters
//   as plain integers reduced modulo 2^CNT_W. A compare process checks every
//   DUT output against that model on each falling edge; directed sequences
//   add hand-computed literal expectations, followed by a randomized run.

module tb_hazard_ctrl;

  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_W        = 8;
  localparam longint unsigned CNT_MASK = (64'd1 << CNT_W) - 64'd1;

  logic             clk;
  logic             rst;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2;
  logic             ex_memread, ex_br_taken, ex_stop;
  logic             mem_busy, resume, cnt_clr;
  logic             stall_f, stall_d, stall_e, flush_d, eflush, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Model state
  bit              m_halted     = 1'b0;
  int              m_drain_left = 0;
  longint unsigned m_sc         = 0;
  longint unsigned m_fc         = 0;

  typedef struct packed {
    logic sf, sd, se, fd, ef, h;
  } ctl_t;

  hazard_ctrl #(
    .DRAIN_CYCLES(DRAIN_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_memread (ex_memread),
    .ex_br_taken(ex_br_taken),
    .ex_stop    (ex_stop),
    .mem_busy   (mem_busy),
    .resume     (resume),
    .cnt_clr    (cnt_clr),
    .stall_f    (stall_f),
    .stall_d    (stall_d),
    .stall_e    (stall_e),
    .flush_d    (flush_d),
    .eflush     (eflush),
    .halted     (halted),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint unsigned actual,
                             input longint unsigned expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected controls for the current cycle, straight from the rules.
  function automatic ctl_t modelCtl();
    ctl_t c;
    bit   hazard;
    c = '0;
    hazard = ex_memread && (ex_rd != 0) &&
             ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
    if (m_halted) begin
      c.h = 1; c.sf = 1; c.fd = 1; c.ef = 1;
    end else if (m_drain_left > 0) begin
      c.sf = 1; c.fd = 1; c.ef = 1; c.se = mem_busy;
    end else if (mem_busy) begin
      c.sf = 1; c.sd = 1; c.se = 1;
    end else if (ex_br_taken) begin
      c.fd = 1; c.ef = 1;
    end else if (ex_stop) begin
      c.sf = 1; c.fd = 1; c.ef = 1;
    end else if (hazard) begin
      c.sf = 1; c.sd = 1; c.ef = 1;
    end
    return c;
  endfunction

  // Model state update on each rising edge using the inputs held across it.
  always @(posedge clk) begin
    ctl_t c;
    c = modelCtl();
    if (rst) begin
      m_halted = 0; m_drain_left = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (cnt_clr) begin
        m_sc = 0; m_fc = 0;
      end else begin
        if (c.sf) m_sc = (m_sc + 1) & CNT_MASK;
        if (!m_halted && m_drain_left == 0 && !mem_busy && ex_br_taken)
          m_fc = (m_fc + 1) & CNT_MASK;
      end
      if (m_halted) begin
        if (resume) m_halted = 0;
      end else if (m_drain_left > 0) begin
        if (!mem_busy) begin
          m_drain_left--;
          if (m_drain_left == 0) m_halted = 1;
        end
      end else if (!mem_busy && !ex_br_taken && ex_stop) begin
        m_drain_left = DRAIN_CYCLES;
      end
    end
  end

  // Compare process: every output against the model on each falling edge.
  always @(negedge clk) begin
    ctl_t e;
    if (check_en) begin
      e = modelCtl();
      checkOutput("stall_f",   stall_f,   e.sf);
      checkOutput("stall_d",   stall_d,   e.sd);
      checkOutput("stall_e",   stall_e,   e.se);
      checkOutput("flush_d",   flush_d,   e.fd);
      checkOutput("eflush",    eflush,    e.ef);
      checkOutput("halted",    halted,    e.h);
      checkOutput("stall_cnt", stall_cnt, m_sc);
      checkOutput("flush_cnt", flush_cnt, m_fc);
    end
  end

  // Starts a new cycle just after the rising edge with all inputs idle.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    rst = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_memread = 0; ex_br_taken = 0; ex_stop = 0;
    mem_busy = 0; resume = 0; cnt_clr = 0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_memread = 0; ex_br_taken = 0; ex_stop = 0;
    mem_busy = 0; resume = 0; cnt_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    check_en = 1;
    @(negedge clk);
    checkOutput("reset stall_f", stall_f, 0);
    checkOutput("reset eflush", eflush, 0);
    checkOutput("reset halted", halted, 0);
    checkOutput("reset stall_cnt", stall_cnt, 0);
    checkOutput("reset flush_cnt", flush_cnt, 0);

    // Load-use on rs2 gives one bubble; the same pattern on x0 gives none.
    applyStimulus(); ex_memread = 1; ex_rd = 5; id_use_rs2 = 1; id_rs2 = 5;
    @(negedge clk);
    checkOutput("lu stall_f", stall_f, 1);
    checkOutput("lu stall_d", stall_d, 1);
    checkOutput("lu eflush", eflush, 1);
    checkOutput("lu flush_d", flush_d, 0);
    applyStimulus(); ex_memread = 1; ex_rd = 0; id_use_rs2 = 1; id_rs2 = 0;
    @(negedge clk);
    checkOutput("x0 stall_f", stall_f, 0);
    checkOutput("x0 eflush", eflush, 0);
    checkOutput("lu stall_cnt", stall_cnt, 1);

    // Taken branch beats a concurrent load-use.
    applyStimulus(); ex_br_taken = 1; ex_memread = 1; ex_rd = 5; id_use_rs1 = 1; id_rs1 = 5;
    @(negedge clk);
    checkOutput("br flush_d", flush_d, 1);
    checkOutput("br eflush", eflush, 1);
    checkOutput("br stall_f", stall_f, 0);
    applyStimulus();
    @(negedge clk);
    checkOutput("br flush_cnt", flush_cnt, 1);

    // Counter clear.
    applyStimulus(); cnt_clr = 1;
    @(negedge clk);
    applyStimulus();
    @(negedge clk);
    checkOutput("clr stall_cnt", stall_cnt, 0);
    checkOutput("clr flush_cnt", flush_cnt, 0);

    // Memory wait holds a pending branch for four cycles.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(); mem_busy = 1; ex_br_taken = 1;
      @(negedge clk);
      checkOutput("busy stall_e", stall_e, 1);
      checkOutput("busy flush_d", flush_d, 0);
    end
    applyStimulus(); ex_br_taken = 1;
    @(negedge clk);
    checkOutput("post-busy flush_d", flush_d, 1);
    checkOutput("post-busy stall_cnt", stall_cnt, 4);
    applyStimulus();
    @(negedge clk);
    checkOutput("post-busy flush_cnt", flush_cnt, 1);

    // ECALL: three drain cycles, then halted, then resume.
    applyStimulus(); ex_stop = 1;
    @(negedge clk);
    checkOutput("ecall stall_f", stall_f, 1);
    checkOutput("ecall eflush", eflush, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      @(negedge clk);
      checkOutput("drain halted", halted, 0);
    end
    applyStimulus(); resume = 1;
    @(negedge clk);
    checkOutput("halt halted", halted, 1);
    applyStimulus();
    @(negedge clk);
    checkOutput("resume halted", halted, 0);
    checkOutput("resume stall_f", stall_f, 0);
    checkOutput("halt stall_cnt", stall_cnt, 9);

    // ECALL with a two-cycle memory wait mid-drain, then reset from HALTED.
    applyStimulus(); ex_stop = 1; cnt_clr = 1;
    @(negedge clk);
    applyStimulus();
    @(negedge clk);
    applyStimulus(); mem_busy = 1;
    @(negedge clk);
    checkOutput("drain busy stall_e", stall_e, 1);
    applyStimulus(); mem_busy = 1;
    @(negedge clk);
    applyStimulus();
    @(negedge clk);
    applyStimulus();
    @(negedge clk);
    checkOutput("drain5 halted", halted, 0);
    applyStimulus();
    @(negedge clk);
    checkOutput("busy-drain halted", halted, 1);
    checkOutput("busy-drain stall_cnt", stall_cnt, 5);
    applyStimulus();
    @(negedge clk);
    applyStimulus(); rst = 1;
    @(negedge clk);
    checkOutput("pre-rst stall_cnt", stall_cnt, 7);
    applyStimulus();
    @(negedge clk);
    checkOutput("rst halted", halted, 0);
    checkOutput("rst stall_cnt", stall_cnt, 0);
    checkOutput("rst stall_f", stall_f, 0);

    // Counter wrap and clear-beats-increment.
    for (int i = 0; i < 255; i++) begin
      applyStimulus(); mem_busy = 1;
      @(negedge clk);
    end
    applyStimulus(); mem_busy = 1;
    @(negedge clk);
    checkOutput("max stall_cnt", stall_cnt, 255);
    applyStimulus(); mem_busy = 1;
    @(negedge clk);
    checkOutput("wrap stall_cnt", stall_cnt, 0);
    applyStimulus(); mem_busy = 1; cnt_clr = 1;
    @(negedge clk);
    checkOutput("clr-busy stall_cnt", stall_cnt, 1);
    applyStimulus();
    @(negedge clk);
    checkOutput("clr-win stall_cnt", stall_cnt, 0);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
      rst         = ($urandom_range(0, 199) == 0);
      mem_busy    = ($urandom_range(0, 3) == 0);
      ex_br_taken = ($urandom_range(0, 5) == 0);
      ex_stop     = ($urandom_range(0, 11) == 0);
      resume      = ($urandom_range(0, 5) == 0);
      cnt_clr     = ($urandom_range(0, 63) == 0);
      ex_memread  = $urandom_range(0, 1) == 1;
      id_use_rs1  = $urandom_range(0, 1) == 1;
      id_use_rs2  = $urandom_range(0, 1) == 1;
      ex_rd       = 5'($urandom_range(0, 3));
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      @(negedge clk);
    end

    applyStimulus();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
